// File: rtl/mips_multicycle_cpu.sv
// Multicycle MIPS-subset core. A single FSM steps each instruction through
// fetch/decode/execute/memory/writeback over one shared req/ready memory port.
// Register 2 (by default) is exposed as error_code. Halt status and the
// retired-instruction count are exposed for the harness.
module mips_multicycle_cpu #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned ERR_REG    = 2,
  parameter int unsigned WAIT_LIMIT = 0,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata,
  input  logic                 mem_ready,
  output logic [31:0]          error_code,
  output logic                 halted,
  output logic [1:0]           halt_cause,
  output logic [CNT_WIDTH-1:0] retired,
  output logic [2:0]           state_dbg
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_ALIGN   = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

  localparam logic [4:0]  ERR_IDX  = 5'(ERR_REG);
  localparam logic [4:0]  LINK_IDX = 5'd31;
  localparam logic [31:0] WAIT_MAX = 32'(WAIT_LIMIT);

  // Architectural and sequencing state
  state_t               r_state;
  logic [31:0]          r_pc;
  logic [31:0]          r_ir;
  logic [31:0]          r_a;
  logic [31:0]          r_b;
  logic [31:0]          r_target;
  logic [31:0]          r_alu;
  logic [31:0]          r_addr;
  logic [31:0]          r_mdr;
  logic [31:0]          r_stall;
  logic [31:0]          r_err;
  logic [31:0]          r_regs [32];
  logic                 r_halted;
  logic [1:0]           r_cause;
  logic [CNT_WIDTH-1:0] r_retired;

  // Instruction fields and datapath wires
  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_dest;
  logic [15:0] w_imm;
  logic [25:0] w_imm26;
  logic [31:0] w_sext;
  logic [31:0] w_target;
  logic [31:0] w_addr;
  logic [31:0] w_alu;
  logic [31:0] w_wb_data;
  logic [31:0] w_stall_inc;
  logic        w_legal;
  logic        w_timeout;
  logic        w_in_access;

  assign w_op        = r_ir[31:26];
  assign w_rs        = r_ir[25:21];
  assign w_rt        = r_ir[20:16];
  assign w_rd        = r_ir[15:11];
  assign w_funct     = r_ir[5:0];
  assign w_imm       = r_ir[15:0];
  assign w_imm26     = r_ir[25:0];
  assign w_sext      = {{16{w_imm[15]}}, w_imm};
  assign w_target    = r_pc + {w_sext[29:0], 2'b00};
  assign w_addr      = r_a + w_sext;
  assign w_dest      = (w_op == OP_RTYPE) ? w_rd : w_rt;
  assign w_wb_data   = (w_op == OP_LW) ? r_mdr : r_alu;
  assign w_stall_inc = r_stall + 32'd1;
  assign w_timeout   = (WAIT_MAX != 32'd0) && (w_stall_inc >= WAIT_MAX);

  // Memory port: request is dropped immediately while reset is held
  assign w_in_access = (r_state == S_FETCH) || (r_state == S_MEM);
  assign mem_req     = w_in_access && !reset;
  assign mem_we      = mem_req && (r_state == S_MEM) && (w_op == OP_SW);
  assign mem_addr    = (r_state == S_MEM) ? r_addr : r_pc;
  assign mem_wdata   = r_b;

  assign error_code = r_err;
  assign halted     = r_halted;
  assign halt_cause = r_cause;
  assign retired    = r_retired;
  assign state_dbg  = r_state;

  // Opcode/funct legality check used in DECODE
  always_comb begin
    w_legal = 1'b0;
    case (w_op)
      OP_RTYPE: w_legal = (w_funct == FN_ADD) || (w_funct == FN_SUB) ||
                          (w_funct == FN_SLT) || (w_funct == FN_JR);
      OP_J, OP_JAL, OP_BNE, OP_XORI, OP_LW, OP_SW: w_legal = 1'b1;
      default: w_legal = 1'b0;
    endcase
  end

  // ALU: XORI uses a zero-extended immediate, SLT is a signed compare
  always_comb begin
    w_alu = r_a + r_b;
    if (w_op == OP_XORI) begin
      w_alu = r_a ^ {16'h0000, w_imm};
    end else if (w_funct == FN_SUB) begin
      w_alu = r_a - r_b;
    end else if (w_funct == FN_SLT) begin
      w_alu = {31'd0, ($signed(r_a) < $signed(r_b))};
    end
  end

  // Control FSM together with PC, IR, register file and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_target  <= '0;
      r_alu     <= '0;
      r_addr    <= '0;
      r_mdr     <= '0;
      r_stall   <= '0;
      r_err     <= '0;
      r_halted  <= 1'b0;
      r_cause   <= 2'd0;
      r_retired <= '0;
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_err <= r_regs[ERR_IDX];
      case (r_state)
        S_FETCH: begin
          if (mem_ready) begin
            r_ir    <= mem_rdata;
            r_pc    <= r_pc + 32'd4;
            r_stall <= '0;
            r_state <= S_DECODE;
          end else if (w_timeout) begin
            r_halted <= 1'b1;
            r_cause  <= CAUSE_TIMEOUT;
            r_state  <= S_HALT;
          end else begin
            r_stall <= w_stall_inc;
          end
        end

        S_DECODE: begin
          r_a      <= r_regs[w_rs];
          r_b      <= r_regs[w_rt];
          r_target <= w_target;
          if (w_legal) begin
            r_state <= S_EXEC;
          end else begin
            r_halted <= 1'b1;
            r_cause  <= CAUSE_ILLEGAL;
            r_state  <= S_HALT;
          end
        end

        S_EXEC: begin
          case (w_op)
            OP_LW, OP_SW: begin
              r_addr <= w_addr;
              if (w_addr[1:0] != 2'b00) begin
                r_halted <= 1'b1;
                r_cause  <= CAUSE_ALIGN;
                r_state  <= S_HALT;
              end else begin
                r_state <= S_MEM;
              end
            end
            OP_BNE: begin
              if (r_a != r_b) begin
                r_pc <= r_target;
              end
              r_retired <= r_retired + CNT_WIDTH'(1);
              r_state   <= S_FETCH;
            end
            OP_J: begin
              r_pc      <= {r_pc[31:28], w_imm26, 2'b00};
              r_retired <= r_retired + CNT_WIDTH'(1);
              r_state   <= S_FETCH;
            end
            OP_JAL: begin
              r_pc             <= {r_pc[31:28], w_imm26, 2'b00};
              r_regs[LINK_IDX] <= r_pc;
              r_retired        <= r_retired + CNT_WIDTH'(1);
              r_state          <= S_FETCH;
            end
            OP_RTYPE: begin
              if (w_funct == FN_JR) begin
                r_pc      <= r_a;
                r_retired <= r_retired + CNT_WIDTH'(1);
                r_state   <= S_FETCH;
              end else begin
                r_alu   <= w_alu;
                r_state <= S_WB;
              end
            end
            default: begin
              r_alu   <= w_alu;
              r_state <= S_WB;
            end
          endcase
        end

        S_MEM: begin
          if (mem_ready) begin
            r_stall <= '0;
            if (w_op == OP_SW) begin
              r_retired <= r_retired + CNT_WIDTH'(1);
              r_state   <= S_FETCH;
            end else begin
              r_mdr   <= mem_rdata;
              r_state <= S_WB;
            end
          end else if (w_timeout) begin
            r_halted <= 1'b1;
            r_cause  <= CAUSE_TIMEOUT;
            r_state  <= S_HALT;
          end else begin
            r_stall <= w_stall_inc;
          end
        end

        S_WB: begin
          if (w_dest != 5'd0) begin
            r_regs[w_dest] <= w_wb_data;
          end
          r_retired <= r_retired + CNT_WIDTH'(1);
          r_state   <= S_FETCH;
        end

        S_HALT: begin
          r_state <= S_HALT;
        end

        default: begin
          r_state <= S_HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_cpu.sv
// Directed bench for mips_multicycle_cpu: ROM/RAM memory model with optional
// random wait states, and cycle-exact checks of the register tap and status.
module tb_mips_multicycle_cpu;

  logic        clk;
  logic        reset;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] error_code;
  logic        halted;
  logic [1:0]  halt_cause;
  logic [31:0] retired;
  logic [2:0]  state_dbg;

  mips_multicycle_cpu #(
    .RESET_PC  (32'h0000_0000),
    .ERR_REG   (2),
    .WAIT_LIMIT(4),
    .CNT_WIDTH (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .error_code(error_code),
    .halted    (halted),
    .halt_cause(halt_cause),
    .retired   (retired),
    .state_dbg (state_dbg)
  );

  localparam logic [31:0] ILL = 32'hFC00_0000;

  // Memory model: ROM below 0x100 (loaded by the stimulus), RAM at 0x100
  logic [31:0] rom [64];
  logic [31:0] ram [64];
  int          mode = 0;       // 0 always ready, 1 random 0..3 waits, 2 never ready
  int unsigned wait_left = 0;
  int          we_cyc = 0;
  int          we_hs = 0;
  int          data_req_cyc = 0;
  logic [31:0] fetch_q [$];

  int total = 0;
  int bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = (mem_addr < 32'h100) ? rom[mem_addr[7:2]] : ram[mem_addr[7:2]];
  assign mem_ready = (mode == 0) ? 1'b1 :
                     (mode == 1) ? (mem_req && (wait_left == 0)) : 1'b0;

  always @(posedge clk) begin
    if (mem_req && mem_ready) begin
      if (mem_we && (mem_addr >= 32'h100)) ram[mem_addr[7:2]] <= mem_wdata;
      wait_left <= (mode == 1) ? $urandom_range(0, 3) : 0;
    end else if (mem_req && (wait_left != 0)) begin
      wait_left <= wait_left - 1;
    end
    if (mem_req && mem_we) we_cyc <= we_cyc + 1;
    if (mem_req && mem_we && mem_ready) we_hs <= we_hs + 1;
    if (mem_req && (state_dbg == 3'd3)) data_req_cyc <= data_req_cyc + 1;
    if (mem_req && mem_ready && (state_dbg == 3'd0)) fetch_q.push_back(mem_addr);
  end

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [31:0] target);
    return {op, target[27:2]};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic load_prog2();
    for (int i = 0; i < 64; i++) rom[i] = ILL;
    rom[0]  = enc_i(6'h23, 5'd0, 5'd4, 16'h0080);      // lw   $4,0x80($0)
    rom[1]  = enc_i(6'h2B, 5'd0, 5'd4, 16'h0100);      // sw   $4,0x100($0)
    rom[2]  = enc_i(6'h23, 5'd0, 5'd2, 16'h0100);      // lw   $2,0x100($0)
    rom[3]  = enc_i(6'h05, 5'd2, 5'd0, 16'd1);         // bne  $2,$0,+1 (taken)
    rom[5]  = enc_i(6'h05, 5'd0, 5'd0, 16'd5);         // bne  $0,$0,+5 (not taken)
    rom[6]  = enc_j(6'h03, 32'h40);                    // jal  0x40
    rom[7]  = enc_i(6'h0E, 5'd0, 5'd5, 16'd1);         // xori $5,$0,1
    rom[8]  = enc_r(5'd0, 5'd5, 5'd6, 6'h22);          // sub  $6,$0,$5
    rom[9]  = enc_r(5'd6, 5'd5, 5'd3, 6'h2A);          // slt  $3,$6,$5
    rom[10] = enc_i(6'h0E, 5'd0, 5'd0, 16'h0055);      // xori $0,$0,0x55
    rom[11] = enc_r(5'd3, 5'd0, 5'd2, 6'h20);          // add  $2,$3,$0
    rom[16] = enc_r(5'd31, 5'd0, 5'd2, 6'h20);         // add  $2,$31,$0
    rom[17] = enc_r(5'd31, 5'd0, 5'd0, 6'h08);         // jr   $31
    rom[32] = 32'hDEAD_BEEF;
  endtask

  initial begin
    logic [31:0] exp_trace [14];
    int f0;
    int w0;
    int d0;
    exp_trace = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h14, 32'h18, 32'h40,
                  32'h44, 32'h1C, 32'h20, 32'h24, 32'h28, 32'h2C, 32'h30};

    // Program 1: xori/xori/add then an illegal opcode
    reset = 1'b1;
    mode  = 0;
    for (int i = 0; i < 64; i++) rom[i] = ILL;
    rom[0] = enc_i(6'h0E, 5'd0, 5'd2, 16'd5);
    rom[1] = enc_i(6'h0E, 5'd0, 5'd3, 16'd7);
    rom[2] = enc_r(5'd2, 5'd3, 5'd2, 6'h20);
    tick(2);
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_cause", 32'(halt_cause), 32'd0);
    check("rst_retired", retired, 32'd0);
    check("rst_err", error_code, 32'd0);
    check("req_low_in_reset", 32'(mem_req), 32'd0);
    reset = 1'b0;
    #1;
    check("req_after_reset", 32'(mem_req), 32'd1);
    check("fetch_addr0", mem_addr, 32'd0);
    tick(12);
    check("p1_retired_12", retired, 32'd3);
    check("p1_err_lag", error_code, 32'd5);
    tick(1);
    check("p1_err_13", error_code, 32'd12);
    tick(1);
    check("p1_halted", 32'(halted), 32'd1);
    check("p1_cause_ill", 32'(halt_cause), 32'd1);
    check("p1_retired_ill", retired, 32'd3);
    check("p1_state_halt", 32'(state_dbg), 32'd5);
    check("p1_req_halt", 32'(mem_req), 32'd0);

    // Reset from HALT, stall, reset mid-stall, then timeout
    mode  = 2;
    reset = 1'b1;
    #1;
    check("req_low_rst2", 32'(mem_req), 32'd0);
    tick(1);
    reset = 1'b0;
    #1;
    check("rst2_err", error_code, 32'd0);
    check("rst2_halted", 32'(halted), 32'd0);
    check("rst2_pc", mem_addr, 32'd0);
    tick(2);
    check("stall_state", 32'(state_dbg), 32'd0);
    check("stall_req", 32'(mem_req), 32'd1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    #1;
    check("midstall_state", 32'(state_dbg), 32'd0);
    check("midstall_req", 32'(mem_req), 32'd1);
    check("midstall_addr", mem_addr, 32'd0);
    check("midstall_retired", retired, 32'd0);
    tick(3);
    check("to_not_yet", 32'(halted), 32'd0);
    check("to_addr_stable", mem_addr, 32'd0);
    tick(1);
    check("to_halted", 32'(halted), 32'd1);
    check("to_cause", 32'(halt_cause), 32'd3);
    check("to_retired", retired, 32'd0);

    // Program 2 with zero-wait memory
    load_prog2();
    reset = 1'b1;
    tick(1);
    mode  = 0;
    reset = 1'b0;
    f0 = fetch_q.size();
    w0 = we_cyc;
    tick(9);
    check("p2_retired_9", retired, 32'd2);
    check("p2_sw_we_cycles", 32'(we_cyc - w0), 32'd1);
    tick(4);
    check("p2_lw_not_done", retired, 32'd2);
    tick(1);
    check("p2_lw_done", retired, 32'd3);
    tick(1);
    check("p2_err_lw", error_code, 32'hDEAD_BEEF);
    tick(13);
    check("p2_err_link", error_code, 32'h0000_001C);
    tick(24);
    check("p2_halted", 32'(halted), 32'd1);
    check("p2_cause", 32'(halt_cause), 32'd1);
    check("p2_retired", retired, 32'd13);
    check("p2_err_slt", error_code, 32'd1);
    check("p2_ram", ram[0], 32'hDEAD_BEEF);
    check("p2_nfetch", 32'(fetch_q.size() - f0), 32'd14);
    for (int k = 0; k < 14; k++) begin
      check($sformatf("p2_fetch%0d", k), fetch_q[f0 + k], exp_trace[k]);
    end

    // Program 2 again with random 0..3 wait states
    reset = 1'b1;
    tick(1);
    mode  = 1;
    reset = 1'b0;
    f0 = fetch_q.size();
    w0 = we_hs;
    for (int i = 0; i < 600; i++) begin
      if (halted) break;
      tick(1);
    end
    check("rw_halted", 32'(halted), 32'd1);
    check("rw_cause", 32'(halt_cause), 32'd1);
    check("rw_retired", retired, 32'd13);
    check("rw_err", error_code, 32'd1);
    check("rw_stores", 32'(we_hs - w0), 32'd1);
    check("rw_nfetch", 32'(fetch_q.size() - f0), 32'd14);
    for (int k = 0; k < 14; k++) begin
      check($sformatf("rw_fetch%0d", k), fetch_q[f0 + k], exp_trace[k]);
    end

    // Misaligned load halts before any data request
    for (int i = 0; i < 64; i++) rom[i] = ILL;
    rom[0] = enc_i(6'h23, 5'd0, 5'd2, 16'h0102);
    reset = 1'b1;
    tick(1);
    mode  = 0;
    reset = 1'b0;
    d0 = data_req_cyc;
    tick(2);
    check("mis_not_yet", 32'(halted), 32'd0);
    tick(1);
    check("mis_halted", 32'(halted), 32'd1);
    check("mis_cause", 32'(halt_cause), 32'd2);
    check("mis_retired", retired, 32'd0);
    check("mis_req", 32'(mem_req), 32'd0);
    tick(3);
    check("mis_no_data_req", 32'(data_req_cyc - d0), 32'd0);
    check("mis_cause_held", 32'(halt_cause), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_cpu.md
Name: mips_multicycle_cpu

Overview:
- Multicycle successor to the single-cycle MIPS core.
- One FSM sequences fetch, decode, execute, memory and writeback over a single unified memory port with a req/ready handshake, so memory may stall.
- The block holds its own PC, IR, 32x32 register file and ALU. It exposes the error-code register tap and halt/diagnostic status to the test harness.
- It is the CPU top for Lab4-style benches and drives an external memory model.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ERR_REG, 2, register index mirrored on error_code.
- WAIT_LIMIT, 0, maximum stall cycles per memory access before halting (0 = unlimited).
- CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- mem_req  out  1  memory access request.
- mem_we  out  1  write strobe, valid while mem_req is high.
- mem_addr  out  32  byte address, word aligned.
- mem_wdata  out  32  store data.
- mem_rdata  in  32  read data, valid when mem_ready is high.
- mem_ready  in  1  access completes at the posedge where mem_req and mem_ready are both high.
- error_code  out  32  registered copy of reg[ERR_REG].
- halted  out  1  core stopped.
- halt_cause  out  2  0 none, 1 illegal opcode/funct, 2 misaligned data address, 3 memory timeout.
- retired  out  CNT_WIDTH  count of completed instructions.
- state_dbg  out  3  current FSM state encoding.

Behaviour:
- Reset (sync, highest priority, any state, including mid-access):
  - PC=RESET_PC, state=FETCH, all registers 0, IR=0, halted=0, halt_cause=0, retired=0, error_code=0, stall counter 0.
  - mem_req falls low in the reset cycle.
- FSM states: FETCH(0), DECODE(1), EXEC(2), MEM(3), WB(4), HALT(5).
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=PC.
  - Hold until mem_ready. Then IR<=mem_rdata, PC<=PC+4, go to DECODE.
- DECODE:
  - Latch A=reg[rs], B=reg[rt].
  - Compute branch target = PC + (sign-extended imm << 2). PC here is already PC+4.
  - Illegal opcode/funct -> HALT with cause 1.
- Supported opcodes: R-type 0x00 (funct ADD 0x20, SUB 0x22, SLT 0x2A, JR 0x08), J 0x02, JAL 0x03, BNE 0x05, XORI 0x0E, LW 0x23, SW 0x2B.
- EXEC:
  - ADD/SUB: 32-bit wraparound; overflow ignored.
  - SLT: signed compare, result 0/1.
  - XORI: zero-extended immediate.
  - LW/SW: address = A + sign-extended imm. If addr[1:0]!=0 -> HALT with cause 2. Otherwise go to MEM.
  - BNE: if A!=B then PC<=target. Retire, go to FETCH.
  - J: PC<={PC[31:28], imm26, 2'b00}. Retire, go to FETCH.
  - JAL: same PC update as J, plus reg[31]<=PC (return address). Retire.
  - JR: PC<=A. Retire.
  - R-type ALU ops and XORI -> WB.
- MEM:
  - mem_req=1, mem_addr=computed address.
  - SW: mem_we=1, mem_wdata=B. On mem_ready, retire and go to FETCH.
  - LW: mem_we=0. On mem_ready, latch MDR and go to WB.
- WB:
  - Write the result to reg[rd] (R-type) or reg[rt] (XORI, LW).
  - Retire, go to FETCH.
- Register 0: writes are discarded; reads return 0.
- Latency with mem_ready tied to 1:
  - BNE/J/JAL/JR: 3 cycles.
  - SW, R-type, XORI: 4 cycles.
  - LW: 5 cycles.
  - Each stall cycle adds one.
- Handshake rules:
  - mem_addr, mem_we and mem_wdata stay stable while mem_req=1 and mem_ready=0.
  - mem_ready is ignored outside FETCH/MEM.
  - mem_req is 0 in every other state.
- Timeout:
  - Stall counter counts consecutive cycles in FETCH/MEM with mem_ready=0.
  - If WAIT_LIMIT!=0 and the counter reaches WAIT_LIMIT -> HALT with cause 3.
  - Counter clears on each completed access.
- HALT:
  - Absorbing until reset. mem_req=0, halted=1.
  - halt_cause is held. The PC is left pointing after the offending instruction.
  - The faulting instruction is not retired.
- retired increments by 1 per completed instruction and wraps at 2^CNT_WIDTH.
- error_code <= reg[ERR_REG] every cycle, one cycle after the register write. It reflects the WB-cycle value from the next cycle on.

Test Plan:
- Reset mid-stall: hold mem_ready=0 in FETCH, assert reset -> next cycle state=FETCH, PC=0, mem_req=1, retired=0.
- Program `xori $2,$0,5; xori $3,$0,7; add $2,$2,$3`, mem_ready=1 -> error_code=12 after 12 cycles plus one; retired=3.
- `sw` then `lw` round trip: store 0xDEADBEEF at 0x100, load into $2 -> error_code=0xDEADBEEF. Load takes 5 cycles; SW asserts mem_we for exactly one cycle.
- Control flow: `bne` taken/not-taken (+2 / fall-through), `jal` sets $31=PC+4, `jr $31` returns -> the instruction sequence is fetched in the expected order; slt of -1 vs 1 yields 1.
- Stalls: memory with 3-cycle random wait, WAIT_LIMIT=0 -> same final state as zero-wait run. WAIT_LIMIT=4 with memory never ready -> halted=1, halt_cause=3 after 4 stall cycles.
- Faults: opcode 0x3F -> halt_cause=1, retired unchanged. `lw` from 0x102 -> halt_cause=2, mem_req never asserted for the data access. Writes to $0 leave it 0.
